// File: rtl/stopwatch_ctrl.sv
// Button sequencer for the BCD stopwatch: debounces start/lap/clear, drives the counter's
// start-toggle and reset, and holds a lap snapshot for the display path.
module stopwatch_ctrl #(
    parameter int unsigned DEB_CYCLES = 250000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_start,
    input  logic        btn_lap,
    input  logic        btn_clr,
    input  logic [23:0] timer_data,
    output logic        start_pulse,
    output logic        timer_reset,
    output logic [23:0] disp_data,
    output logic        running,
    output logic        lap_mode
);

    localparam int unsigned      CNT_W   = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StLap,
        StPause
    } state_e;

    // Bit 0 = start, bit 1 = lap, bit 2 = clear.
    logic [2:0]       w_btn_raw;
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_stable;
    logic [2:0]       r_armed;
    logic [2:0]       r_evt;
    logic [CNT_W-1:0] r_cnt [3];
    logic [1:0]       r_fill;
    logic             w_filled;

    logic             w_ev_start;
    logic             w_ev_lap;
    logic             w_ev_clr;

    state_e           r_state;
    state_e           w_state_d;
    logic             w_start_d;
    logic             w_treset_d;
    logic             w_lap_cap;

    logic             r_start_pulse;
    logic             r_timer_reset;
    logic             r_running;
    logic             r_lap_mode;
    logic [23:0]      r_lap;
    logic [23:0]      r_disp;

    assign w_btn_raw = {btn_clr, btn_lap, btn_start};
    assign w_filled  = (r_fill == 2'd2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_fill  <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            if (!w_filled) begin
                r_fill <= r_fill + 2'd1;
            end
        end
    end

    // A button only becomes armed once it has been seen released after reset, so a button
    // held through reset is accepted silently and cannot fire until pressed again.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stable <= '0;
            r_armed  <= '0;
            r_evt    <= '0;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_evt[i] <= 1'b0;
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                    if (w_filled && !r_stable[i]) begin
                        r_armed[i] <= 1'b1;
                    end
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_cnt[i]    <= '0;
                    r_stable[i] <= r_sync2[i];
                    r_evt[i]    <= r_sync2[i] & r_armed[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // One event per cycle; lower-priority coincident events are dropped.
    assign w_ev_start = r_evt[0];
    assign w_ev_lap   = r_evt[1] & ~r_evt[0];
    assign w_ev_clr   = r_evt[2] & ~r_evt[1] & ~r_evt[0];

    always_comb begin
        w_state_d  = r_state;
        w_start_d  = 1'b0;
        w_treset_d = 1'b0;
        w_lap_cap  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_ev_start) begin
                    w_state_d = StRun;
                    w_start_d = 1'b1;
                end else if (w_ev_clr) begin
                    w_treset_d = 1'b1;
                end
            end
            StRun: begin
                if (w_ev_start) begin
                    w_state_d = StPause;
                    w_start_d = 1'b1;
                end else if (w_ev_lap) begin
                    w_state_d = StLap;
                    w_lap_cap = 1'b1;
                end
            end
            StLap: begin
                if (w_ev_start) begin
                    w_state_d = StPause;
                    w_start_d = 1'b1;
                end else if (w_ev_lap) begin
                    w_lap_cap = 1'b1;
                end else if (w_ev_clr) begin
                    w_state_d = StRun;
                end
            end
            StPause: begin
                if (w_ev_start) begin
                    w_state_d = StRun;
                    w_start_d = 1'b1;
                end else if (w_ev_clr) begin
                    w_state_d  = StIdle;
                    w_treset_d = 1'b1;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= StIdle;
            r_start_pulse <= 1'b0;
            r_timer_reset <= 1'b1;
            r_running     <= 1'b0;
            r_lap_mode    <= 1'b0;
            r_lap         <= '0;
            r_disp        <= '0;
        end else begin
            r_state       <= w_state_d;
            r_start_pulse <= w_start_d;
            r_timer_reset <= w_treset_d;
            r_running     <= (w_state_d == StRun) || (w_state_d == StLap);
            r_lap_mode    <= (w_state_d == StLap);
            if (w_lap_cap) begin
                r_lap <= timer_data;
            end
            r_disp <= r_lap_mode ? r_lap : timer_data;
        end
    end

    assign start_pulse = r_start_pulse;
    assign timer_reset = r_timer_reset;
    assign disp_data   = r_disp;
    assign running     = r_running;
    assign lap_mode    = r_lap_mode;

endmodule
